// File: rtl/idelay_tap_sweep_ctrl.sv
// Tap sequencer for the clk_delay IDELAYE2: sets one tap or sweeps a tap range, gating
// every load on IDELAYCTRL ready and holding off tap_valid until the delay line settles.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for start; single-mode tap_valid may still be held
// WAIT_RDY | target chosen, waiting for IDELAYCTRL RDY
// LOAD     | delay already carries target; ld/ldpipeen pulse next cycle
// SETTLE   | ld issued, counting the settle window
// DWELL    | sweep tap stable, tap_valid high for max(dwell,1) cycles
// DONE     | one-cycle done pulse
module idelay_tap_sweep_ctrl #(
   parameter int TAP_W      = 5,
   parameter int TAP_MIN    = 0,
   parameter int TAP_MAX    = 31,
   parameter int TAP_STEP   = 1,
   parameter int SETTLE_CYC = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             idly_rdy,
   input  logic             start,
   input  logic             stop,
   input  logic             mode,
   input  logic [TAP_W-1:0] tap_req,
   input  logic [15:0]      dwell,
   output logic [TAP_W-1:0] delay,
   output logic             ld,
   output logic             ldpipeen,
   output logic             tap_valid,
   output logic             busy,
   output logic             done
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WAIT_RDY = 3'd1,
      S_LOAD     = 3'd2,
      S_SETTLE   = 3'd3,
      S_DWELL    = 3'd4,
      S_DONE     = 3'd5
   } state_t;

   localparam logic [TAP_W-1:0] MIN_TAP   = TAP_W'(TAP_MIN);
   localparam logic [TAP_W-1:0] MAX_TAP   = TAP_W'(TAP_MAX);
   localparam logic [TAP_W:0]   MAX_EXT   = (TAP_W+1)'(TAP_MAX);
   localparam logic [TAP_W:0]   STEP_EXT  = (TAP_W+1)'(TAP_STEP);
   localparam logic [15:0]      SETTLE_LD = 16'(SETTLE_CYC);

   state_t           state;
   state_t           state_nxt;
   logic             mode_q;
   logic [15:0]      dwell_q;
   logic [15:0]      dwell_last;
   logic [15:0]      cnt;
   logic             cnt_zero;
   logic [TAP_W-1:0] target;
   logic [TAP_W-1:0] target_nxt;
   logic [TAP_W-1:0] req_clamped;
   logic [TAP_W:0]   tap_nxt;
   logic             last_tap;
   logic             accept;

   logic [TAP_W-1:0] delay_d;
   logic             ld_d;
   logic             tv_d;
   logic             busy_d;
   logic             done_d;

   assign accept      = (state == S_IDLE) && start && !stop;
   assign cnt_zero    = (cnt == 16'd0);
   assign req_clamped = (tap_req > MAX_TAP) ? MAX_TAP : tap_req;
   // One extra bit so a step past TAP_MAX is seen as an overflow instead of wrapping to 0.
   assign tap_nxt     = {1'b0, delay} + STEP_EXT;
   assign last_tap    = (tap_nxt > MAX_EXT);
   assign dwell_last  = (dwell_q == 16'd0) ? 16'd0 : (dwell_q - 16'd1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (stop && (state != S_IDLE)) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) state_nxt = idly_rdy ? S_LOAD : S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
               if (idly_rdy) state_nxt = S_LOAD;
            end
            S_LOAD: begin
               state_nxt = idly_rdy ? S_SETTLE : S_WAIT_RDY;
            end
            S_SETTLE: begin
               if (!idly_rdy)    state_nxt = S_WAIT_RDY;
               else if (cnt_zero) state_nxt = mode_q ? S_DWELL : S_DONE;
            end
            S_DWELL: begin
               if (!idly_rdy)    state_nxt = S_WAIT_RDY;
               else if (cnt_zero) state_nxt = last_tap ? S_DONE : S_LOAD;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      target_nxt = target;
      if (accept) begin
         target_nxt = mode ? MIN_TAP : req_clamped;
      end else if ((state == S_DWELL) && (state_nxt == S_LOAD)) begin
         target_nxt = tap_nxt[TAP_W-1:0];
      end
   end

   // Outputs are registered, so these are the values for the state being entered.
   always_comb begin
      delay_d = (state_nxt == S_LOAD) ? target_nxt : delay;
      ld_d    = (state == S_LOAD) && (state_nxt == S_SETTLE);
      busy_d  = (state_nxt != S_IDLE);
      done_d  = (state_nxt == S_DONE);
      tv_d    = tap_valid;
      if (state == S_IDLE) begin
         if (accept) tv_d = 1'b0;
      end else if (stop || (state_nxt == S_WAIT_RDY)) begin
         tv_d = 1'b0;
      end else if ((state == S_SETTLE) && (state_nxt != S_SETTLE)) begin
         tv_d = 1'b1;
      end else if ((state == S_DWELL) && (state_nxt != S_DWELL)) begin
         tv_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         delay     <= MIN_TAP;
         ld        <= 1'b0;
         ldpipeen  <= 1'b0;
         tap_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         delay     <= delay_d;
         ld        <= ld_d;
         ldpipeen  <= ld_d;
         tap_valid <= tv_d;
         busy      <= busy_d;
         done      <= done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q  <= 1'b0;
         dwell_q <= 16'd0;
         target  <= MIN_TAP;
         cnt     <= 16'd0;
      end else begin
         target <= target_nxt;
         if (accept) begin
            mode_q  <= mode;
            dwell_q <= dwell;
         end
         // The settle window is counted from the cycle after ld, hence the full SETTLE_CYC load.
         if ((state_nxt == S_SETTLE) && (state != S_SETTLE)) begin
            cnt <= SETTLE_LD;
         end else if ((state_nxt == S_DWELL) && (state != S_DWELL)) begin
            cnt <= dwell_last;
         end else if ((state_nxt == state) && ((state == S_SETTLE) || (state == S_DWELL))
                      && !cnt_zero) begin
            cnt <= cnt - 16'd1;
         end else begin
            cnt <= 16'd0;
         end
      end
   end

endmodule

// File: tb/tb_idelay_tap_sweep_ctrl.sv
// Bench for idelay_tap_sweep_ctrl: three parameterisations driven with directed scenarios,
// each scenario expanded into a per-cycle expected output timeline.
module tb_idelay_tap_sweep_ctrl;

   typedef struct packed {
      logic [4:0] dly;
      logic       ld;
      logic       tv;
      logic       busy;
      logic       done;
   } exp_t;

   localparam int SETTLE = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        idly_rdy;
   logic        stop;
   logic        mode;
   logic [4:0]  tap_req;
   logic [15:0] dwell;
   logic        start_v [3];
   logic [4:0]  dly     [3];
   logic        ld_o    [3];
   logic        lp_o    [3];
   logic        tv_o    [3];
   logic        busy_o  [3];
   logic        done_o  [3];

   always #5 clk = ~clk;

   idelay_tap_sweep_ctrl u_a (
      .clk(clk), .rst(rst), .idly_rdy(idly_rdy), .start(start_v[0]), .stop(stop),
      .mode(mode), .tap_req(tap_req), .dwell(dwell), .delay(dly[0]), .ld(ld_o[0]),
      .ldpipeen(lp_o[0]), .tap_valid(tv_o[0]), .busy(busy_o[0]), .done(done_o[0]));

   idelay_tap_sweep_ctrl #(.TAP_MAX(20)) u_b (
      .clk(clk), .rst(rst), .idly_rdy(idly_rdy), .start(start_v[1]), .stop(stop),
      .mode(mode), .tap_req(tap_req), .dwell(dwell), .delay(dly[1]), .ld(ld_o[1]),
      .ldpipeen(lp_o[1]), .tap_valid(tv_o[1]), .busy(busy_o[1]), .done(done_o[1]));

   idelay_tap_sweep_ctrl #(.TAP_STEP(4), .TAP_MAX(30)) u_c (
      .clk(clk), .rst(rst), .idly_rdy(idly_rdy), .start(start_v[2]), .stop(stop),
      .mode(mode), .tap_req(tap_req), .dwell(dwell), .delay(dly[2]), .ld(ld_o[2]),
      .ldpipeen(lp_o[2]), .tap_valid(tv_o[2]), .busy(busy_o[2]), .done(done_o[2]));

   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   bit   chk_en = 1'b0;
   exp_t hold [3];
   exp_t q0 [$];
   exp_t q1 [$];
   exp_t q2 [$];

   int ld_cnt       [3] = '{0, 0, 0};
   int done_cnt     [3] = '{0, 0, 0};
   int last_ld_cyc  [3] = '{0, 0, 0};
   int last_ld_dly  [3] = '{0, 0, 0};
   int last_tv_rise [3] = '{0, 0, 0};
   bit prev_tv      [3] = '{1'b0, 1'b0, 1'b0};

   int launch_cyc;
   int base_ld;
   int base_done;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int tmax(input int i);
      return (i == 0) ? 31 : ((i == 1) ? 20 : 30);
   endfunction

   function automatic int tstep(input int i);
      return (i == 2) ? 4 : 1;
   endfunction

   function automatic int qsize(input int i);
      case (i)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   task automatic push(input int i, input exp_t v);
      case (i)
         0:       q0.push_back(v);
         1:       q1.push_back(v);
         default: q2.push_back(v);
      endcase
   endtask

   function automatic exp_t pop_exp(input int i);
      exp_t e;
      e = hold[i];
      case (i)
         0:       if (q0.size() > 0) e = q0.pop_front();
         1:       if (q1.size() > 0) e = q1.pop_front();
         default: if (q2.size() > 0) e = q2.pop_front();
      endcase
      return e;
   endfunction

   task automatic chk(input string nm, input int act, input int expv);
      n_chk++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 3; i++) begin
            exp_t e;
            exp_t a;
            e = pop_exp(i);
            a.dly = dly[i]; a.ld = ld_o[i]; a.tv = tv_o[i]; a.busy = busy_o[i]; a.done = done_o[i];
            n_chk++;
            if ((a !== e) || (lp_o[i] !== e.ld)) begin
               n_fail++;
               $display("FAIL trace u%0d cyc %0d: got dly=%0d ld=%0b lp=%0b tv=%0b busy=%0b done=%0b, expected dly=%0d ld=%0b lp=%0b tv=%0b busy=%0b done=%0b",
                        i, cyc, a.dly, a.ld, lp_o[i], a.tv, a.busy, a.done,
                        e.dly, e.ld, e.ld, e.tv, e.busy, e.done);
            end
            if (ld_o[i] === 1'b1) begin
               ld_cnt[i]++;
               last_ld_cyc[i] = cyc;
               last_ld_dly[i] = int'(dly[i]);
            end
            if (done_o[i] === 1'b1) done_cnt[i]++;
            if ((tv_o[i] === 1'b1) && !prev_tv[i]) last_tv_rise[i] = cyc;
            prev_tv[i] = (tv_o[i] === 1'b1);
         end
      end
   end

   // Expected timeline from the start cycle on: per tap one LOAD cycle, the ld cycle, SETTLE
   // cycles, then (sweep) the dwell cycles; finally DONE. kind 1=stop, 2=rst, 3=ready drop for
   // gap cycles, 4=stray start, each applied in the cycle rel cycles after ld of tap cut_tap.
   task automatic plan(input int i, input bit md, input int req, input int dw, input int cut_tap,
                       input int cut_off, input int kind, input int gap, output int cut_idx);
      exp_t v;
      int   taps [$];
      int   dwe;
      int   j;
      int   last;
      bit   cut_done;
      bit   retry;
      cut_idx  = -1;
      cut_done = 1'b0;
      dwe      = (dw == 0) ? 1 : dw;
      if (md) begin
         for (int t = 0; t <= tmax(i); t += tstep(i)) taps.push_back(t);
      end else begin
         taps.push_back((req > tmax(i)) ? tmax(i) : req);
      end
      push(i, hold[i]);
      j = 0;
      while (j < taps.size()) begin
         retry = 1'b0;
         last  = md ? (SETTLE + dwe) : SETTLE;
         for (int r = -1; r <= last; r++) begin
            v.dly  = 5'(taps[j]);
            v.ld   = (r == 0);
            v.tv   = md && (r > SETTLE);
            v.busy = 1'b1;
            v.done = 1'b0;
            push(i, v);
            if (!cut_done && (taps[j] == cut_tap) && (r == cut_off)) begin
               cut_done = 1'b1;
               cut_idx  = qsize(i) - 1;
               if (kind == 1 || kind == 2) begin
                  v = '0;
                  if (kind == 1) v.dly = 5'(taps[j]);
                  push(i, v);
                  hold[i] = v;
                  return;
               end
               if (kind == 3) begin
                  v.ld = 1'b0;
                  v.tv = 1'b0;
                  repeat (gap) push(i, v);
                  retry = 1'b1;
                  break;
               end
            end
         end
         if (!retry) j++;
      end
      v.dly  = 5'(taps[taps.size()-1]);
      v.ld   = 1'b0;
      v.tv   = !md;
      v.busy = 1'b1;
      v.done = 1'b1;
      push(i, v);
      v.busy  = 1'b0;
      v.done  = 1'b0;
      hold[i] = v;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int i, input bit md, input int req, input int dw, input int cut_tap,
                      input int cut_off, input int kind, input int gap);
      int cut;
      int n;
      mode       = md;
      tap_req    = 5'(req);
      dwell      = 16'(dw);
      launch_cyc = cyc;
      base_ld    = ld_cnt[i];
      base_done  = done_cnt[i];
      start_v[i] = 1'b1;
      plan(i, md, req, dw, cut_tap, cut_off, kind, gap, cut);
      tick();
      start_v[i] = 1'b0;
      n = 1;
      while ((qsize(i) > 0) && (n < 5000)) begin
         stop       = (kind == 1) && (n == cut);
         rst        = (kind == 2) && (n == cut);
         idly_rdy   = !((kind == 3) && (n >= cut) && (n < cut + gap));
         start_v[i] = (kind == 4) && (n == cut);
         if ((kind == 4) && (n == cut)) begin
            mode    = !md;
            tap_req = 5'd3;
         end
         tick();
         if ((kind == 2) && (n == cut)) begin
            for (int k = 0; k < 3; k++) if (k != i) hold[k] = '0;
         end
         n++;
      end
      stop       = 1'b0;
      rst        = 1'b0;
      idly_rdy   = 1'b1;
      start_v[i] = 1'b0;
      if (qsize(i) > 0) begin
         chk("timeline_drained", qsize(i), 0);
      end
      tick();
   endtask

   initial begin
      rst      = 1'b1;
      idly_rdy = 1'b1;
      stop     = 1'b0;
      mode     = 1'b0;
      tap_req  = 5'd0;
      dwell    = 16'd0;
      for (int i = 0; i < 3; i++) begin
         start_v[i] = 1'b0;
         hold[i]    = '0;
      end
      tick();
      chk_en = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("reset_delay_a", int'(dly[0]), 0);
      chk("reset_busy_b", int'(busy_o[1]), 0);
      chk("reset_tv_c", int'(tv_o[2]), 0);

      // single set, tap 7
      run(0, 1'b0, 7, 0, -1, 0, 0, 0);
      chk("s1_ld_latency", last_ld_cyc[0] - launch_cyc, 2);
      chk("s1_ld_delay", last_ld_dly[0], 7);
      chk("s1_tv_after_ld", last_tv_rise[0] - last_ld_cyc[0], 17);
      chk("s1_done_count", done_cnt[0] - base_done, 1);
      chk("s1_busy_low", int'(busy_o[0]), 0);
      chk("s1_tv_held", int'(tv_o[0]), 1);

      // clamp to TAP_MAX=20, and tap at the top of the default range
      run(1, 1'b0, 31, 0, -1, 0, 0, 0);
      chk("s2_clamp_delay", last_ld_dly[1], 20);
      chk("s2_done_count", done_cnt[1] - base_done, 1);
      chk("s2_tv_held", int'(tv_o[1]), 1);
      run(0, 1'b0, 31, 0, -1, 0, 0, 0);
      chk("s2_max_tap", last_ld_dly[0], 31);

      // full sweep, dwell 3
      run(0, 1'b1, 0, 3, -1, 0, 0, 0);
      chk("s3_ld_count", ld_cnt[0] - base_ld, 32);
      chk("s3_done_count", done_cnt[0] - base_done, 1);
      chk("s3_final_delay", int'(dly[0]), 31);
      chk("s3_tv_off", int'(tv_o[0]), 0);

      // step 4 up to 30, then dwell 0 behaving as 1
      run(2, 1'b1, 0, 2, -1, 0, 0, 0);
      chk("s4_ld_count", ld_cnt[2] - base_ld, 8);
      chk("s4_final_delay", int'(dly[2]), 28);
      run(2, 1'b1, 0, 0, -1, 0, 0, 0);
      chk("s4_dwell0_ld_count", ld_cnt[2] - base_ld, 8);

      // ready lost for 10 cycles mid-dwell at tap 5
      run(0, 1'b1, 0, 3, 5, SETTLE + 2, 3, 10);
      chk("s5_ld_count", ld_cnt[0] - base_ld, 33);
      chk("s5_done_count", done_cnt[0] - base_done, 1);

      // stop during SETTLE at tap 9
      run(0, 1'b1, 0, 3, 9, 5, 1, 0);
      chk("s6_ld_count", ld_cnt[0] - base_ld, 10);
      chk("s6_no_done", done_cnt[0] - base_done, 0);
      chk("s6_delay_held", int'(dly[0]), 9);
      chk("s6_busy_low", int'(busy_o[0]), 0);

      // start together with stop in IDLE is ignored
      for (int i = 0; i < 3; i++) start_v[i] = 1'b1;
      stop = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
      stop = 1'b0;
      repeat (3) tick();
      chk("s7_ignored_a", int'(busy_o[0]), 0);
      chk("s7_ignored_c", int'(busy_o[2]), 0);

      // start while busy is ignored
      run(0, 1'b0, 12, 0, 12, 4, 4, 0);
      chk("s8_ld_count", ld_cnt[0] - base_ld, 1);
      chk("s8_delay", int'(dly[0]), 12);

      // reset mid-sweep
      run(0, 1'b1, 0, 3, 3, 10, 2, 0);
      chk("s9_delay_a", int'(dly[0]), 0);
      chk("s9_busy_a", int'(busy_o[0]), 0);
      chk("s9_delay_b", int'(dly[1]), 0);
      chk("s9_tv_b", int'(tv_o[1]), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
